id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the MIPS pipeline, sitting between fetch and execute and directly in front of the synchronous-read register file. It presents rs/rt read addresses to the register file, holds the decoded instruction while the register file's one-cycle read completes, bypasses same-cycle and in-flight writebacks, and hands a decoded operand bundle to execute through a valid/ready handshake.

## Interface
Parameters:
- `XLEN`, default 32: data width.

Ports:
- `i_clk` in 1: clock; all state updates on its rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: fetch offers `i_instr`/`i_pc`.
- `i_instr` in 32: instruction word.
- `i_pc` in 32: instruction address.
- `o_ready` out 1: stage can accept this cycle.
- `o_raddr1`, `o_raddr2` out 5: register-file read addresses (rs, rt).
- `i_rdata1`, `i_rdata2` in XLEN: register-file data, one cycle after address.
- `i_wb_we` in 1, `i_wb_waddr` in 5, `i_wb_wdata` in XLEN: writeback port, identical to the register-file write port.
- `i_flush` in 1: discard held and incoming instruction.
- `o_valid` out 1: decoded bundle valid.
- `i_ready` in 1: execute accepts bundle.
- `o_pc` out 32, `o_rs_val` out XLEN, `o_rt_val` out XLEN, `o_imm` out XLEN, `o_rd` out 5, `o_alu_op` out 4, `o_alu_src_imm` out 1, `o_we` out 1, `o_mem_rd` out 1, `o_mem_wr` out 1, `o_branch` out 1, `o_illegal` out 1.

## Operation
- Single holding register S1 (valid bit, instruction, pc). `o_valid` = S1 valid.
- Accept when `i_valid && o_ready`; `o_ready = !S1.valid || i_ready`.
- Read addresses: `o_raddr* = (S1.valid && !i_ready) ? S1 fields : i_instr fields`. The register file re-reads the held instruction every stall cycle.
- Decode fields: rs=[25:21], rt=[20:16], rd=[15:11], op=[31:26], funct=[5:0].
- Supported: R-type ADD/SUB/AND/OR/SLT (op 0), ADDI, ANDI, ORI, LW, SW, BEQ.
- Destination: rd for R-type; rt for ADDI/ANDI/ORI/LW; none for SW/BEQ.
- `o_we` = destination exists && destination != 0.
- Immediate: ANDI/ORI zero-extend; all others sign-extend [15:0].
- Unsupported op/funct: `o_illegal`=1; `o_we`, `o_mem_rd`, `o_mem_wr`, `o_branch` forced 0.
- Bypass, per operand, in priority order:
  - (1) live: `i_wb_we && i_wb_waddr==rs && rs!=0` → `i_wb_wdata`;
  - (2) captured: a writeback matching on the edge S1 last read, stored in a bypass register with hit flag;
  - (3) `i_rdata`.
  - Register 0 always reads 0 regardless of `i_rdata`.
- `i_flush`: S1.valid←0 next edge; the incoming instruction is dropped even if offered. Flush beats accept.

## Timing
- Reset: S1.valid=0, bypass hit flags=0, every output 0.
- Reset or flush mid-stall discards the held instruction; nothing is emitted.
- Latency: instruction accepted at edge N → `o_valid`=1 with correct operands after edge N, consumable at edge N+1.
- Throughput: 1 instruction per cycle when `i_ready` stays high.
- Stall (`o_valid && !i_ready`): all `o_*` bundle fields hold except `o_rs_val`/`o_rt_val`, which must reflect writebacks arriving during the stall.
- A writeback on the same edge that execute consumes the bundle is visible through live bypass.

## Structure
- Shared package `mips_pkg`: opcode/funct constants and the `alu_op` encoding (ADD=0, SUB=1, AND=2, OR=3, SLT=4).
- Package also holds the XLEN default.
- One combinational sub-module, `instr_decoder` (instruction → control/immediate/destination). Bypass logic and S1 live in `id_stage`.

## Test plan
- Reset, then ADDI r3,r0,-5 (0x2003FFFB) with `i_ready`=1 → next cycle `o_valid`=1, `o_imm`=0xFFFFFFFB, `o_rd`=3, `o_we`=1, `o_alu_op`=ADD.
- ORI r2,r1,0x8000 → `o_imm`=0x00008000; R-type write to r0 → `o_we`=0.
- Writeback r5=0x1234 on the acceptance edge of ADD r6,r5,r5 while the register file returns the stale 0 → `o_rs_val`=`o_rt_val`=0x1234.
- Hold `i_ready`=0 for 3 cycles; writeback r5=0xBEEF in cycle 2 → `o_rs_val`=0xBEEF from cycle 2 onward, `o_ready`=0 throughout, other fields unchanged.
- Assert `i_flush` with S1 valid and `i_valid`=1 → next cycle `o_valid`=0; neither instruction is emitted.
- Op 0x3F → `o_illegal`=1 and `o_we`, `o_mem_rd`, `o_mem_wr`, `o_branch` all 0; assert `i_rst` mid-stall → all outputs 0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, ALU operation encoding
// and the default datapath width.
package mips_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational MIPS decoder: instruction word to register fields,
// immediate, destination and execute/memory control.
module instr_decoder
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     i_instr,
  output logic [4:0]      o_rs,
  output logic [4:0]      o_rt,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rd,
  output logic [3:0]      o_alu_op,
  output logic            o_alu_src_imm,
  output logic            o_we,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic            o_branch,
  output logic            o_illegal
);

  logic [5:0]      op;
  logic [5:0]      funct;
  logic [XLEN-1:0] imm_sx;
  logic [XLEN-1:0] imm_zx;
  logic [4:0]      dest;
  alu_op_e         alu_op;

  assign op     = i_instr[31:26];
  assign funct  = i_instr[5:0];
  assign o_rs   = i_instr[25:21];
  assign o_rt   = i_instr[20:16];
  assign imm_sx = {{(XLEN-16){i_instr[15]}}, i_instr[15:0]};
  assign imm_zx = {{(XLEN-16){1'b0}}, i_instr[15:0]};

  // NOTE: every output gets a default before the case, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    alu_op        = ALU_ADD;
    o_alu_src_imm = 1'b0;
    o_mem_rd      = 1'b0;
    o_mem_wr      = 1'b0;
    o_branch      = 1'b0;
    o_illegal     = 1'b0;
    o_imm         = imm_sx;
    dest          = 5'd0;
    case (op)
      OP_RTYPE: begin
        dest = i_instr[15:11];
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: begin
            o_illegal = 1'b1;
            dest      = 5'd0;
          end
        endcase
      end
      OP_ADDI: begin
        o_alu_src_imm = 1'b1;
        dest          = o_rt;
      end
      OP_ANDI: begin
        alu_op        = ALU_AND;
        o_alu_src_imm = 1'b1;
        o_imm         = imm_zx;
        dest          = o_rt;
      end
      OP_ORI: begin
        alu_op        = ALU_OR;
        o_alu_src_imm = 1'b1;
        o_imm         = imm_zx;
        dest          = o_rt;
      end
      OP_LW: begin
        o_alu_src_imm = 1'b1;
        o_mem_rd      = 1'b1;
        dest          = o_rt;
      end
      OP_SW: begin
        o_alu_src_imm = 1'b1;
        o_mem_wr      = 1'b1;
      end
      OP_BEQ: begin
        alu_op   = ALU_SUB;
        o_branch = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

  // Writes to r0 are architecturally void, so they never assert the enable.
  assign o_rd     = dest;
  assign o_we     = (dest != 5'd0);
  assign o_alu_op = alu_op;

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: holds one instruction while the synchronous register
// file read completes, bypasses writebacks and hands a bundle to execute.
module id_stage
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [31:0]     i_instr,
  input  logic [31:0]     i_pc,
  output logic            o_ready,
  output logic [4:0]      o_raddr1,
  output logic [4:0]      o_raddr2,
  input  logic [XLEN-1:0] i_rdata1,
  input  logic [XLEN-1:0] i_rdata2,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_waddr,
  input  logic [XLEN-1:0] i_wb_wdata,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_pc,
  output logic [XLEN-1:0] o_rs_val,
  output logic [XLEN-1:0] o_rt_val,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rd,
  output logic [3:0]      o_alu_op,
  output logic            o_alu_src_imm,
  output logic            o_we,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic            o_branch,
  output logic            o_illegal
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     pc_q, pc_d;
  logic            byp1_hit_q, byp1_hit_d;
  logic            byp2_hit_q, byp2_hit_d;
  logic [XLEN-1:0] byp1_data_q, byp1_data_d;
  logic [XLEN-1:0] byp2_data_q, byp2_data_d;

  logic            stall;
  logic            accept;

  logic [4:0]      dec_rs, dec_rt, dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu_op;
  logic            dec_alu_src_imm, dec_we, dec_mem_rd, dec_mem_wr;
  logic            dec_branch, dec_illegal;

  instr_decoder #(.XLEN(XLEN)) u_decoder (
    .i_instr       (instr_q),
    .o_rs          (dec_rs),
    .o_rt          (dec_rt),
    .o_imm         (dec_imm),
    .o_rd          (dec_rd),
    .o_alu_op      (dec_alu_op),
    .o_alu_src_imm (dec_alu_src_imm),
    .o_we          (dec_we),
    .o_mem_rd      (dec_mem_rd),
    .o_mem_wr      (dec_mem_wr),
    .o_branch      (dec_branch),
    .o_illegal     (dec_illegal)
  );

  // Operand priority: r0, live writeback, writeback captured at the read edge,
  // then register-file data (which misses a write on its own read edge).
  function automatic logic [XLEN-1:0] operand(
    input logic [4:0]      addr,
    input logic            cap_hit,
    input logic [XLEN-1:0] cap_data,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_we,
    input logic [4:0]      wb_addr,
    input logic [XLEN-1:0] wb_data
  );
    if (addr == 5'd0)                 return '0;
    if (wb_we && (wb_addr == addr))   return wb_data;
    if (cap_hit)                      return cap_data;
    return rf_data;
  endfunction

  assign stall    = valid_q && !i_ready;
  assign o_ready  = !valid_q || i_ready;
  assign accept   = i_valid && o_ready && !i_flush;
  assign o_raddr1 = stall ? dec_rs : i_instr[25:21];
  assign o_raddr2 = stall ? dec_rt : i_instr[20:16];

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      instr_d = i_instr;
      pc_d    = i_pc;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
    // The register file reads o_raddr* on every edge, so capture whatever
    // writeback lands on that same edge for the address being read.
    byp1_hit_d  = i_wb_we && (i_wb_waddr == o_raddr1) && (o_raddr1 != 5'd0);
    byp2_hit_d  = i_wb_we && (i_wb_waddr == o_raddr2) && (o_raddr2 != 5'd0);
    byp1_data_d = i_wb_wdata;
    byp2_data_d = i_wb_wdata;
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the payload is cleared along with the valid bit; it is small and
      // this keeps the held instruction deterministic after reset.
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
      byp1_hit_q  <= 1'b0;
      byp2_hit_q  <= 1'b0;
      byp1_data_q <= '0;
      byp2_data_q <= '0;
    end else begin
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      byp1_hit_q  <= byp1_hit_d;
      byp2_hit_q  <= byp2_hit_d;
      byp1_data_q <= byp1_data_d;
      byp2_data_q <= byp2_data_d;
    end
  end

  assign o_valid = valid_q;

  // The bundle reads as all zeros whenever nothing is held.
  always_comb begin
    o_pc          = '0;
    o_rs_val      = '0;
    o_rt_val      = '0;
    o_imm         = '0;
    o_rd          = '0;
    o_alu_op      = '0;
    o_alu_src_imm = 1'b0;
    o_we          = 1'b0;
    o_mem_rd      = 1'b0;
    o_mem_wr      = 1'b0;
    o_branch      = 1'b0;
    o_illegal     = 1'b0;
    if (valid_q) begin
      o_pc          = pc_q;
      o_rs_val      = operand(dec_rs, byp1_hit_q, byp1_data_q, i_rdata1,
                              i_wb_we, i_wb_waddr, i_wb_wdata);
      o_rt_val      = operand(dec_rt, byp2_hit_q, byp2_data_q, i_rdata2,
                              i_wb_we, i_wb_waddr, i_wb_wdata);
      o_imm         = dec_imm;
      o_rd          = dec_rd;
      o_alu_op      = dec_alu_op;
      o_alu_src_imm = dec_alu_src_imm;
      o_we          = dec_we;
      o_mem_rd      = dec_mem_rd;
      o_mem_wr      = dec_mem_wr;
      o_branch      = dec_branch;
      o_illegal     = dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a register-file model feeds the DUT, a
// reference decoder fills the expected queue, a negedge monitor compares.
module tb_id_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        src_imm;
    logic        we;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_instr = '0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_rdata1 = '0;
  logic [31:0] i_rdata2 = '0;
  logic        i_wb_we = 1'b0;
  logic [4:0]  i_wb_waddr = '0;
  logic [31:0] i_wb_wdata = '0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b0;

  logic        o_ready, o_valid;
  logic [4:0]  o_raddr1, o_raddr2, o_rd;
  logic [31:0] o_pc, o_rs_val, o_rt_val, o_imm;
  logic [3:0]  o_alu_op;
  logic        o_alu_src_imm, o_we, o_mem_rd, o_mem_wr, o_branch, o_illegal;

  id_stage #(.XLEN(32)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .i_instr       (i_instr),
    .i_pc          (i_pc),
    .o_ready       (o_ready),
    .o_raddr1      (o_raddr1),
    .o_raddr2      (o_raddr2),
    .i_rdata1      (i_rdata1),
    .i_rdata2      (i_rdata2),
    .i_wb_we       (i_wb_we),
    .i_wb_waddr    (i_wb_waddr),
    .i_wb_wdata    (i_wb_wdata),
    .i_flush       (i_flush),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_pc          (o_pc),
    .o_rs_val      (o_rs_val),
    .o_rt_val      (o_rt_val),
    .o_imm         (o_imm),
    .o_rd          (o_rd),
    .o_alu_op      (o_alu_op),
    .o_alu_src_imm (o_alu_src_imm),
    .o_we          (o_we),
    .o_mem_rd      (o_mem_rd),
    .o_mem_wr      (o_mem_wr),
    .o_branch      (o_branch),
    .o_illegal     (o_illegal)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  logic        mon_en  = 1'b0;
  logic        m_valid = 1'b0;
  exp_t        sb_q[$];
  logic [31:0] regs [32];
  logic [31:0] pc_next = 32'h0000_1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural register value as execute must see it right now.
  function automatic logic [31:0] arch_val(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (i_wb_we && i_wb_waddr == r) return i_wb_wdata;
    return regs[r];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    op = ins[31:26];
    fn = ins[5:0];
    e = '0;
    e.pc  = pc;
    e.rs  = ins[25:21];
    e.rt  = ins[20:16];
    e.imm = {{16{ins[15]}}, ins[15:0]};
    if (op == 6'h00 && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) begin
      e.rd = ins[15:11];
      e.alu_op = (fn == 6'h20) ? 4'd0 : (fn == 6'h22) ? 4'd1 :
                 (fn == 6'h24) ? 4'd2 : (fn == 6'h25) ? 4'd3 : 4'd4;
    end else if (op == 6'h08) begin
      e.rd = ins[20:16]; e.src_imm = 1'b1;
    end else if (op == 6'h0C || op == 6'h0D) begin
      e.rd = ins[20:16]; e.src_imm = 1'b1;
      e.alu_op = (op == 6'h0C) ? 4'd2 : 4'd3;
      e.imm = {16'h0, ins[15:0]};
    end else if (op == 6'h23) begin
      e.rd = ins[20:16]; e.src_imm = 1'b1; e.mem_rd = 1'b1;
    end else if (op == 6'h2B) begin
      e.src_imm = 1'b1; e.mem_wr = 1'b1;
    end else if (op == 6'h04) begin
      e.alu_op = 4'd1; e.branch = 1'b1;
    end else begin
      e.illegal = 1'b1;
    end
    e.we = !e.illegal && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  fn;
    int          k;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    k   = $urandom_range(0, 12);
    case (k)
      0:       fn = 6'h20;
      1:       fn = 6'h22;
      2:       fn = 6'h24;
      3:       fn = 6'h25;
      4:       fn = 6'h2A;
      default: fn = 6'h21;
    endcase
    case (k)
      0, 1, 2, 3, 4, 5: return {6'h00, rs, rt, rd, imm[10:6], fn};
      6:                return {6'h08, rs, rt, imm};
      7:                return {6'h0C, rs, rt, imm};
      8:                return {6'h0D, rs, rt, imm};
      9:                return {6'h23, rs, rt, imm};
      10:               return {6'h2B, rs, rt, imm};
      11:               return {6'h04, rs, rt, imm};
      default:          return {6'h3F, rs, rt, imm};
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl, input logic rst);
    i_valid    = v;
    i_instr    = ins;
    i_pc       = pc_next;
    pc_next    = pc_next + 32'd4;
    i_ready    = rdy;
    i_wb_we    = we;
    i_wb_waddr = wa;
    i_wb_wdata = wd;
    i_flush    = fl;
    i_rst      = rst;
  endtask

  // One clock: register-file model (read-before-write) and reference S1 update.
  task automatic tick();
    logic [4:0]  a1, a2;
    logic [31:0] rd1, rd2;
    logic        acc;
    @(negedge clk);
    a1 = o_raddr1;
    a2 = o_raddr2;
    @(posedge clk);
    rd1 = regs[a1];
    rd2 = regs[a2];
    acc = i_valid && (!m_valid || i_ready) && !i_flush && !i_rst;
    if (i_rst || i_flush) begin
      sb_q.delete();
      m_valid = 1'b0;
    end else begin
      if (m_valid && i_ready && sb_q.size() != 0) sb_q.delete(0);
      if (acc) sb_q.push_back(ref_decode(i_instr, i_pc));
      m_valid = acc || (m_valid && !i_ready);
    end
    if (i_wb_we) regs[i_wb_waddr] = i_wb_wdata;
    #1;
    i_rdata1 = rd1;
    i_rdata2 = rd2;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      e = '0;
      if (m_valid && sb_q.size() != 0) e = sb_q[0];
      check("o_valid", 32'(o_valid), 32'(m_valid));
      check("o_ready", 32'(o_ready), 32'(!m_valid || i_ready));
      check("o_raddr1", 32'(o_raddr1), 32'((m_valid && !i_ready) ? e.rs : i_instr[25:21]));
      check("o_raddr2", 32'(o_raddr2), 32'((m_valid && !i_ready) ? e.rt : i_instr[20:16]));
      check("o_pc", o_pc, e.pc);
      check("o_imm", o_imm, e.imm);
      check("o_rd", 32'(o_rd), 32'(e.rd));
      check("o_alu_op", 32'(o_alu_op), 32'(e.alu_op));
      check("o_alu_src_imm", 32'(o_alu_src_imm), 32'(e.src_imm));
      check("o_we", 32'(o_we), 32'(e.we));
      check("o_mem_rd", 32'(o_mem_rd), 32'(e.mem_rd));
      check("o_mem_wr", 32'(o_mem_wr), 32'(e.mem_wr));
      check("o_branch", 32'(o_branch), 32'(e.branch));
      check("o_illegal", 32'(o_illegal), 32'(e.illegal));
      check("o_rs_val", o_rs_val, m_valid ? arch_val(e.rs) : 32'h0);
      check("o_rt_val", o_rt_val, m_valid ? arch_val(e.rt) : 32'h0);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[0] = 32'hDEAD_0000;  // a misbehaving r0 must never reach an operand

    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    tick(); tick();
    mon_en = 1'b1;

    // ADDI r3,r0,-5
    drive(1'b1, 32'h2003FFFB, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1 check("reset_valid", 32'(o_valid), 32'h0);
    tick();
    // ORI r2,r1,0x8000
    drive(1'b1, 32'h34228000, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check("addi_valid", 32'(o_valid), 32'h1);
    check("addi_imm", o_imm, 32'hFFFFFFFB);
    check("addi_rd", 32'(o_rd), 32'd3);
    check("addi_we", 32'(o_we), 32'h1);
    check("addi_alu", 32'(o_alu_op), 32'd0);
    tick();
    // ADD r0,r1,r2
    drive(1'b1, 32'h00220020, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1 check("ori_imm", o_imm, 32'h00008000);
    tick();
    // ADD r6,r5,r5 accepted on the edge that writes r5=0x1234
    drive(1'b1, 32'h00A53020, 1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0);
    #1 check("add_r0_we", 32'(o_we), 32'h0);
    tick();
    drive(1'b1, 32'h2003FFFB, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check("capt_rs", o_rs_val, 32'h1234);
    check("capt_rt", o_rt_val, 32'h1234);
    check("stall1_ready", 32'(o_ready), 32'h0);
    tick();
    drive(1'b1, 32'h2003FFFB, 1'b0, 1'b1, 5'd5, 32'hBEEF, 1'b0, 1'b0);
    #1;
    check("stall2_rs", o_rs_val, 32'hBEEF);
    check("stall2_rt", o_rt_val, 32'hBEEF);
    check("stall2_ready", 32'(o_ready), 32'h0);
    tick();
    drive(1'b1, 32'h2003FFFB, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check("stall3_rs", o_rs_val, 32'hBEEF);
    check("stall3_rd", 32'(o_rd), 32'd6);
    check("stall3_ready", 32'(o_ready), 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1 check("release_rs", o_rs_val, 32'hBEEF);
    tick();

    // Flush with an instruction held and another offered
    drive(1'b1, 32'h00A53020, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h2003FFFB, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1 check("preflush_valid", 32'(o_valid), 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1 check("flush_valid", 32'(o_valid), 32'h0);
    tick();

    // Illegal opcode, then reset in the middle of a stall
    drive(1'b1, 32'hFC031234, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check("ill_illegal", 32'(o_illegal), 32'h1);
    check("ill_ctrl", {28'h0, o_we, o_mem_rd, o_mem_wr, o_branch}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_illegal", 32'(o_illegal), 32'h0);
    check("rst_pc", o_pc, 32'h0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 32) == 0, $urandom_range(0, 99) == 0);
      tick();
    end

    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
